// File: rtl/seg_scan_decoder.sv
// Display-bus monitor: filters the multiplexed seven-segment scan, decodes each
// stable digit back to hex and reassembles the displayed word.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_L,
    input  logic [NUM_DIGITS-1:0]     an_L,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      frame_strobe,
    output logic                      err_illegal,
    output logic                      err_anode
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic [CW-1:0]         CNT_EVAL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]         CNT_SAT  = CW'(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic [SW-1:0]           sample_q, sample_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_n;
    logic                    fv_q, fv_d;
    logic                    strobe_q, strobe_d;
    logic                    illegal_q, illegal_d;
    logic                    anode_q, anode_d;
    logic [NUM_DIGITS-1:0]   an_low;
    logic [4:0]              dec;

    // Returns {legal, nibble} for an active-high segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign sample_d = {an_L, seg_L};
    assign an_low   = ~sample_q[SW-1:7];
    assign dec      = decode(~sample_q[6:0]);

    // Saturating one past the evaluation point guarantees a single evaluation per window.
    always_comb begin
        cnt_d = cnt_q;
        if (sample_d != sample_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        value_d   = value_q;
        dv_d      = dv_q;
        mask_n    = mask_q;
        illegal_d = 1'b0;
        anode_d   = 1'b0;
        strobe_d  = 1'b0;
        if (cnt_q == CNT_EVAL && an_low != '0) begin
            if ((an_low & (an_low - AN_ONE)) != '0) begin
                anode_d = 1'b1;
            end else if (dec[4]) begin
                dv_d   = dv_q | an_low;
                mask_n = mask_q | an_low;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_low[i]) value_d[4*i +: 4] = dec[3:0];
                end
            end else begin
                illegal_d = 1'b1;
                dv_d      = dv_q & ~an_low;
                mask_n    = mask_q & ~an_low;
            end
        end
        mask_d = mask_n;
        if (&mask_n) begin
            strobe_d = 1'b1;
            mask_d   = '0;
        end
        fv_d = &dv_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q  <= '1;
            cnt_q     <= '0;
            value_q   <= '0;
            dv_q      <= '0;
            mask_q    <= '0;
            fv_q      <= 1'b0;
            strobe_q  <= 1'b0;
            illegal_q <= 1'b0;
            anode_q   <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            dv_q      <= dv_d;
            mask_q    <= mask_d;
            fv_q      <= fv_d;
            strobe_q  <= strobe_d;
            illegal_q <= illegal_d;
            anode_q   <= anode_d;
        end
    end

    assign value        = value_q;
    assign digit_valid  = dv_q;
    assign frame_valid  = fv_q;
    assign frame_strobe = strobe_q;
    assign err_illegal  = illegal_q;
    assign err_anode    = anode_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a 4-digit/4-cycle instance driven from a
// vector table plus hand sequences, and an 8-digit/2-cycle instance scanning all glyphs.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a;
    logic [7:0]  an_b;
    logic [15:0] value_a;
    logic [3:0]  dv_a;
    logic        fv_a, st_a, il_a, ae_a;
    logic [31:0] value_b;
    logic [7:0]  dv_b;
    logic        fv_b, st_b, il_b, ae_b;

    int errors = 0;
    int checks = 0;
    int n_st_a, n_il_a, n_ae_a, n_st_b, n_il_b, n_ae_b;
    logic [6:0]  seg_tab [16];
    logic [31:0] exp_b;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] ev;
        logic [3:0]  edv;
        logic        efv;
        int          est;
        int          eil;
        int          ean;
    } vec_t;
    vec_t vec [14];

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .seg_L(seg_a), .an_L(an_a),
        .value(value_a), .digit_valid(dv_a), .frame_valid(fv_a),
        .frame_strobe(st_a), .err_illegal(il_a), .err_anode(ae_a)
    );

    seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .seg_L(seg_b), .an_L(an_b),
        .value(value_b), .digit_valid(dv_b), .frame_valid(fv_b),
        .frame_strobe(st_b), .err_illegal(il_b), .err_anode(ae_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_st_a = 0; n_il_a = 0; n_ae_a = 0;
        n_st_b = 0; n_il_b = 0; n_ae_b = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each edge and counting pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n_st_a += int'(st_a); n_il_a += int'(il_a); n_ae_a += int'(ae_a);
            n_st_b += int'(st_b); n_il_b += int'(il_b); n_ae_b += int'(ae_b);
        end
    endtask

    task automatic check_a(input string tag, input logic [15:0] ev, input logic [3:0] edv,
                           input logic efv, input int est, input int eil, input int ean);
        check({tag, ".value"}, 32'(value_a), 32'(ev));
        check({tag, ".digit_valid"}, 32'(dv_a), 32'(edv));
        check({tag, ".frame_valid"}, 32'(fv_a), 32'(efv));
        check({tag, ".strobes"}, 32'(n_st_a), 32'(est));
        check({tag, ".illegal"}, 32'(n_il_a), 32'(eil));
        check({tag, ".anode"}, 32'(n_ae_a), 32'(ean));
    endtask

    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
        seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
        seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
        seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

        vec[0]  = '{4'b1110, ~7'h06, 5, 16'h0001, 4'b0001, 1'b0, 0, 0, 0};
        vec[1]  = '{4'b1111, 7'h7F,  2, 16'h0001, 4'b0001, 1'b0, 0, 0, 0};
        vec[2]  = '{4'b1101, ~7'h5B, 5, 16'h0021, 4'b0011, 1'b0, 0, 0, 0};
        vec[3]  = '{4'b1111, 7'h7F,  2, 16'h0021, 4'b0011, 1'b0, 0, 0, 0};
        vec[4]  = '{4'b1011, ~7'h4F, 5, 16'h0321, 4'b0111, 1'b0, 0, 0, 0};
        vec[5]  = '{4'b1111, 7'h7F,  2, 16'h0321, 4'b0111, 1'b0, 0, 0, 0};
        vec[6]  = '{4'b0111, ~7'h66, 5, 16'h4321, 4'b1111, 1'b1, 1, 0, 0};
        vec[7]  = '{4'b1111, 7'h7F,  2, 16'h4321, 4'b1111, 1'b1, 0, 0, 0};
        vec[8]  = '{4'b1101, ~7'h00, 5, 16'h4321, 4'b1101, 1'b0, 0, 1, 0};
        vec[9]  = '{4'b1110, ~7'h6F, 3, 16'h4321, 4'b1101, 1'b0, 0, 0, 0};
        vec[10] = '{4'b1100, ~7'h6F, 5, 16'h4321, 4'b1101, 1'b0, 0, 0, 1};
        vec[11] = '{4'b1111, 7'h7F,  2, 16'h4321, 4'b1101, 1'b0, 0, 0, 0};
        vec[12] = '{4'b1101, ~7'h07, 8, 16'h4371, 4'b1111, 1'b1, 0, 0, 0};
        vec[13] = '{4'b1111, 7'h7F,  2, 16'h4371, 4'b1111, 1'b1, 0, 0, 0};

        seg_a = 7'h7F; an_a = 4'hF;
        seg_b = 7'h7F; an_b = 8'hFF;
        clr();
        tick(2);
        check_a("reset", 16'h0000, 4'b0000, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        tick(3);

        // Single digit held 8 cycles: capture exactly at edge 5, nothing afterwards.
        clr();
        an_a = 4'b1110; seg_a = ~7'h5B;
        tick(4);
        check_a("hold_pre", 16'h0000, 4'b0000, 1'b0, 0, 0, 0);
        tick(1);
        check_a("hold_cap", 16'h0002, 4'b0001, 1'b0, 0, 0, 0);
        clr();
        tick(3);
        check_a("hold_post", 16'h0002, 4'b0001, 1'b0, 0, 0, 0);

        for (int v = 0; v < 14; v++) begin
            clr();
            an_a = vec[v].an; seg_a = vec[v].seg;
            tick(vec[v].hold);
            check_a($sformatf("vec%0d", v), vec[v].ev, vec[v].edv, vec[v].efv,
                    vec[v].est, vec[v].eil, vec[v].ean);
        end

        // Reset mid-window: immediate clear, then a full window is needed after release.
        clr();
        an_a = 4'b1011; seg_a = ~7'h6D;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check_a("async_rst", 16'h0000, 4'b0000, 1'b0, 0, 0, 0);
        check("async_rst.pulses", 32'({st_a, il_a, ae_a}), 32'h0);
        tick(1);
        rst_n = 1'b1;
        clr();
        tick(4);
        check_a("rst_pre", 16'h0000, 4'b0000, 1'b0, 0, 0, 0);
        tick(1);
        check_a("rst_cap", 16'h0500, 4'b0100, 1'b0, 0, 0, 0);

        clr();
        an_a = 4'hF; seg_a = 7'h7F;
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check_a("rst_blank", 16'h0000, 4'b0000, 1'b0, 0, 0, 0);

        // Wide instance: scan F..8 then 7..0 on digits 7..0, covering every glyph.
        for (int pass = 0; pass < 2; pass++) begin
            clr();
            exp_b = value_b;
            for (int d = 7; d >= 0; d--) begin
                an_b = ~(8'b1 << d);
                seg_b = ~seg_tab[(pass == 0) ? 8 + d : d];
                tick(3);
                exp_b[4*d +: 4] = 4'((pass == 0) ? 8 + d : d);
                check($sformatf("b%0d.digit%0d", pass, d), value_b, exp_b);
                an_b = 8'hFF; seg_b = 7'h7F;
                tick(1);
            end
            check($sformatf("b%0d.word", pass), value_b, (pass == 0) ? 32'hFEDCBA98 : 32'h76543210);
            check($sformatf("b%0d.digit_valid", pass), 32'(dv_b), 32'hFF);
            check($sformatf("b%0d.frame_valid", pass), 32'(fv_b), 32'h1);
            check($sformatf("b%0d.strobes", pass), 32'(n_st_b), 32'h1);
            check($sformatf("b%0d.errors", pass), 32'(n_il_b + n_ae_b), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
